// File: rtl/neuromorphic_wb_pkg.sv
// Shared types and constants for the Neuromorphic_X1 Wishbone initiator.
package neuromorphic_wb_pkg;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
  localparam int unsigned DEFAULT_TIMEOUT  = 255;

endpackage

// File: rtl/neuromorphic_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module neuromorphic_cmd_fifo
  import neuromorphic_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  cmd_t                           wdata,
  output cmd_t                           rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  cmd_t            mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/neuromorphic_wb_initiator.sv
// Wishbone classic initiator: queues single read/write commands and issues each as one
// non-pipelined bus cycle, returning exactly one response (data or timeout error) per command.
module neuromorphic_wb_initiator
  import neuromorphic_wb_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_we_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_dat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW   = $clog2(CMD_DEPTH + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              cyc_q, cyc_d;
  cmd_t              bus_cmd_q, bus_cmd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;

  cmd_t              fifo_wdata, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;

  assign fifo_wdata = '{we: cmd_we_i, sel: cmd_sel_i, adr: cmd_adr_i, dat: cmd_dat_i};
  assign fifo_push  = cmd_valid_i & ~fifo_full;

  neuromorphic_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cyc_d       = cyc_q;
    bus_cmd_d   = bus_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          bus_cmd_d = fifo_head;
          cyc_d     = 1'b1;
          timer_d   = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        // The head entry stays queued until the bus cycle finishes either way.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          fifo_pop    = 1'b1;
          rsp_we_d    = bus_cmd_q.we;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = bus_cmd_q.we ? 32'h0 : wbm_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (timer_q == TimerLast) begin
          cyc_d       = 1'b0;
          fifo_pop    = 1'b1;
          rsp_we_d    = bus_cmd_q.we;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = ERR_DATA;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      bus_cmd_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      bus_cmd_q   <= bus_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign cmd_ready_o = ~fifo_full;
  assign busy_o      = (fifo_count != '0) || (state_q != StIdle);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = bus_cmd_q.we;
  assign wbm_sel_o   = bus_cmd_q.sel;
  assign wbm_adr_o   = bus_cmd_q.adr;
  assign wbm_dat_o   = bus_cmd_q.dat;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_neuromorphic_wb_initiator.sv
// Scoreboard bench for neuromorphic_wb_initiator with a simple Wishbone target model.
module tb_neuromorphic_wb_initiator;
  import neuromorphic_wb_pkg::*;

  localparam int unsigned Timeout = 8;
  localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_we, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack, busy;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i = '0;

  logic stall = 1'b0, force_ack = 1'b0, ack_drv = 1'b0;
  int   ack_dly = 2;
  assign wbm_ack = ack_drv | force_ack;

  typedef struct {
    logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] dat; logic noack;
  } wb_exp_t;
  typedef struct { logic we; logic err; logic [31:0] dat; } rsp_exp_t;

  wb_exp_t  wb_q[$];
  rsp_exp_t rsp_q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  neuromorphic_wb_initiator #(
    .CMD_DEPTH (4),
    .TIMEOUT   (Timeout),
    .ERR_DATA  (ErrData)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_sel_i   (cmd_sel),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_we_o    (rsp_we),
    .rsp_err_o   (rsp_err),
    .rsp_dat_o   (rsp_dat),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack),
    .busy_o      (busy)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] adr);
    return adr ^ 32'h2234_5668;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input logic noack);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      wb_q.push_back('{we: we, sel: sel, adr: adr, dat: dat, noack: noack});
      if (noack) rsp_q.push_back('{we: we, err: 1'b1, dat: ErrData});
      else       rsp_q.push_back('{we: we, err: 1'b0, dat: we ? 32'h0 : rd_model(adr)});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rsp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 500), 32'd1);
  endtask

  // Target model: checks each bus cycle's fields every stb cycle, acks after ack_dly cycles.
  initial begin
    wb_exp_t cur;
    int      hi_cnt = 0;
    logic    acked = 1'b0;
    cur = '{we: 1'b0, sel: 4'h0, adr: 32'h0, dat: 32'h0, noack: 1'b0};
    forever begin
      @(negedge clk);
      #1;
      if (ack_drv) begin
        check("cyc_after_ack", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
        ack_drv = 1'b0;
        acked   = 1'b1;
      end
      if (wbm_cyc && wbm_stb) begin
        if (hi_cnt == 0) begin
          acked = 1'b0;
          if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
          else cur = wb_q.pop_front();
        end
        check("wb_we", 32'(wbm_we), 32'(cur.we));
        check("wb_sel", 32'(wbm_sel), 32'(cur.sel));
        check("wb_adr", wbm_adr, cur.adr);
        check("wb_dat", wbm_dat_o, cur.dat);
        hi_cnt++;
        if (!stall && !cur.noack && hi_cnt > ack_dly) begin
          ack_drv   = 1'b1;
          wbm_dat_i = cur.we ? 32'h0BAD_0BAD : rd_model(wbm_adr);
        end
      end else begin
        if (hi_cnt != 0 && !acked && cur.noack) check("timeout_len", 32'(hi_cnt), Timeout);
        hi_cnt = 0;
      end
    end
  end

  // Response monitor: every accepted response is compared against the scoreboard.
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_we", 32'(rsp_we), 32'(e.we));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_dat", rsp_dat, e.dat);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_cyc_stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, then single read
    push_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A, 1'b0);
    wait_idle();
    push_cmd(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b0);
    wait_idle();

    // Mixed traffic with varying target latency
    for (int i = 0; i < 8; i++) begin
      ack_dly = $urandom_range(0, 3);
      push_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom, 1'b0);
    end
    wait_idle();
    ack_dly = 2;

    // Fill the FIFO against a stalled target
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(i[0], 4'h3, 32'h3000_0100 + 32'(i * 4), 32'(i), 1'b0);
    check("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_we = 1'b0; cmd_sel = 4'hC; cmd_adr = 32'h3000_0200; cmd_dat = 32'h0;
    @(negedge clk);
    check("full_no_push", 32'(cmd_ready), 32'd0);
    stall = 1'b0;
    push_cmd(1'b0, 4'hC, 32'h3000_0200, 32'h0, 1'b0);
    wait_idle();

    // Timeout, then a normal command behind it
    push_cmd(1'b0, 4'hF, 32'h3000_0300, 32'h0, 1'b1);
    push_cmd(1'b1, 4'h3, 32'h3000_0304, 32'h1357_9BDF, 1'b0);
    wait_idle();

    // Response back-pressure
    rsp_ready = 1'b0;
    push_cmd(1'b0, 4'hF, 32'h3000_0400, 32'h0, 1'b0);
    push_cmd(1'b1, 4'hF, 32'h3000_0404, 32'h2468_ACE0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_dat_hold", rsp_dat, rd_model(32'h3000_0400));
      check("bp_no_cyc", 32'(wbm_cyc), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a bus cycle with two commands queued
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 4'hF, 32'h3000_0500 + 32'(i * 4), 32'(i), 1'b0);
    check("mid_in_req", 32'(wbm_cyc), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cyc_stb", {30'h0, wbm_cyc, wbm_stb}, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    wb_q.delete();
    rsp_q.delete();
    rst_n = 1'b1;
    stall = 1'b0;
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_cyc", 32'(wbm_cyc), 32'd0);
      check("late_ack_rsp", 32'(rsp_valid), 32'd0);
      check("late_ack_busy", 32'(busy), 32'd0);
    end
    force_ack = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
